// File: rtl/pc_predict_flush_unit_pkg.sv
// Shared constants for the PC predict / flush unit.
// Counter encodings and saturating counter helpers.
package pc_predict_flush_unit_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    localparam logic [1:0] CNT_RESET = CNT_SNT;
    localparam logic [1:0] CNT_ALLOC = CNT_WT;

    function automatic logic [1:0] cnt_inc(input logic [1:0] c);
        return (c == CNT_ST) ? CNT_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] cnt_dec(input logic [1:0] c);
        return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/pc_predict_flush_unit_if.sv
// Fetch / resolve bundle between the pipeline and the predictor.
// The pipeline side is master, the predictor side is slave.
interface pc_predict_flush_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] fetch_pc;
    logic            stall;
    logic            resolve_valid;
    logic            resolve_is_ctrl;
    logic [XLEN-1:0] resolve_pc;
    logic            resolve_taken;
    logic [XLEN-1:0] resolve_target;
    logic [XLEN-1:0] next_pc;
    logic            is_flush;
    logic [31:0]     mispredict_count;

    modport master (
        output fetch_pc, stall,
        output resolve_valid, resolve_is_ctrl,
        output resolve_pc, resolve_taken, resolve_target,
        input  next_pc, is_flush, mispredict_count
    );

    modport slave (
        input  fetch_pc, stall,
        input  resolve_valid, resolve_is_ctrl,
        input  resolve_pc, resolve_taken, resolve_target,
        output next_pc, is_flush, mispredict_count
    );
endinterface

// File: rtl/pc_predict_flush_unit_btb_table.sv
// Direct-mapped BTB with 2-bit direction counters.
// Lookup is combinational on current state; update on clock edge.
module btb_table
    import pc_predict_flush_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-3:0] lk_pc_i,
    output logic            lk_taken_o,
    output logic [XLEN-1:0] lk_target_o,
    input  logic            up_valid_i,
    input  logic            up_ctrl_i,
    input  logic            up_taken_i,
    input  logic [XLEN-3:0] up_pc_i,
    input  logic [XLEN-1:0] up_target_i
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    logic [ENTRIES-1:0] vld_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];
    logic [1:0]         cnt_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             lk_hit;
    logic             up_hit;

    assign lk_idx = lk_pc_i[IDX_W-1:0];
    assign lk_tag = lk_pc_i[XLEN-3:IDX_W];
    assign up_idx = up_pc_i[IDX_W-1:0];
    assign up_tag = up_pc_i[XLEN-3:IDX_W];

    assign lk_hit = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = vld_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign lk_taken_o  = lk_hit && cnt_q[lk_idx][1];
    assign lk_target_o = tgt_q[lk_idx];

    // Train the indexed entry from each resolved instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= CNT_RESET;
            end
        end else if (up_valid_i) begin
            if (up_ctrl_i && up_taken_i) begin
                tgt_q[up_idx] <= up_target_i;
                if (up_hit) begin
                    cnt_q[up_idx] <= cnt_inc(cnt_q[up_idx]);
                end else begin
                    vld_q[up_idx] <= 1'b1;
                    tag_q[up_idx] <= up_tag;
                    cnt_q[up_idx] <= CNT_ALLOC;
                end
            end else if (up_ctrl_i) begin
                if (up_hit) begin
                    cnt_q[up_idx] <= cnt_dec(cnt_q[up_idx]);
                end
            end else if (up_hit) begin
                vld_q[up_idx] <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pc_predict_flush_unit.sv
// Next-PC prediction with an in-flight prediction queue.
// Flushes when the oldest prediction disagrees with resolution.
module pc_predict_flush_unit
    import pc_predict_flush_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BTB_ENTRIES    = 16,
    parameter int RESOLVE_STAGES = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pc_predict_flush_unit_if.slave  bus
);
    localparam int RS = RESOLVE_STAGES;

    logic            bt_taken;
    logic [XLEN-1:0] bt_target;
    logic [XLEN-1:0] pred_next;
    logic [XLEN-1:0] actual_next;
    logic            flush;

    logic [RS-1:0]   qv_q;
    logic [RS-1:0]   qv_d;
    logic [XLEN-1:0] qp_q [RS];
    logic [XLEN-1:0] qp_d [RS];
    logic [31:0]     cnt_q;
    logic [31:0]     cnt_d;

    btb_table #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .reset_n     (reset_n),
        .lk_pc_i     (bus.fetch_pc[XLEN-1:2]),
        .lk_taken_o  (bt_taken),
        .lk_target_o (bt_target),
        .up_valid_i  (bus.resolve_valid),
        .up_ctrl_i   (bus.resolve_is_ctrl),
        .up_taken_i  (bus.resolve_taken),
        .up_pc_i     (bus.resolve_pc[XLEN-1:2]),
        .up_target_i (bus.resolve_target)
    );

    assign pred_next = bt_taken ? bt_target
                                : bus.fetch_pc + XLEN'(4);

    assign actual_next =
        (bus.resolve_is_ctrl && bus.resolve_taken)
            ? bus.resolve_target
            : bus.resolve_pc + XLEN'(4);

    assign flush = bus.resolve_valid && qv_q[RS-1] &&
                   (qp_q[RS-1] != actual_next);

    assign bus.is_flush         = flush;
    assign bus.next_pc          = flush ? actual_next : pred_next;
    assign bus.mispredict_count = cnt_q;

    // Queue next state: flush clears, stall holds, else shift in.
    always_comb begin
        qv_d = qv_q;
        qp_d = qp_q;
        if (flush) begin
            qv_d = '0;
        end else if (!bus.stall) begin
            qv_d[0] = 1'b1;
            qp_d[0] = pred_next;
            for (int i = 1; i < RS; i++) begin
                qv_d[i] = qv_q[i-1];
                qp_d[i] = qp_q[i-1];
            end
        end
    end

    // Saturating mispredict counter next state.
    always_comb begin
        cnt_d = cnt_q;
        if (flush && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Register queue and mispredict counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qv_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RS; i++) begin
                qp_q[i] <= '0;
            end
        end else begin
            qv_q  <= qv_d;
            qp_q  <= qp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pc_predict_flush_unit.sv
// Directed bench for pc_predict_flush_unit.
// Hand-computed next_pc / flush / count expectations.
module tb_pc_predict_flush_unit;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    pc_predict_flush_unit_if #(.XLEN(32)) bus ();

    pc_predict_flush_unit #(
        .XLEN           (32),
        .BTB_ENTRIES    (16),
        .RESOLVE_STAGES (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [31:0] pc,
                       input logic        stl,
                       input logic        rv,
                       input logic        ctl,
                       input logic [31:0] rpc,
                       input logic        tk,
                       input logic [31:0] tgt);
        bus.fetch_pc        = pc;
        bus.stall           = stl;
        bus.resolve_valid   = rv;
        bus.resolve_is_ctrl = ctl;
        bus.resolve_pc      = rpc;
        bus.resolve_taken   = tk;
        bus.resolve_target  = tgt;
    endtask

    task automatic idle(input logic [31:0] pc);
        drv(pc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Apply inputs, check combinational outputs, then clock.
    task automatic step(input string tag,
                        input logic [31:0] exp_pc,
                        input logic        exp_fl,
                        input logic [31:0] exp_cnt);
        #2;
        chk({tag, ".next_pc"}, bus.next_pc, exp_pc);
        chk({tag, ".flush"}, {31'b0, bus.is_flush}, {31'b0, exp_fl});
        chk({tag, ".count"}, bus.mispredict_count, exp_cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        idle(32'h100);
        repeat (2) @(posedge clk);
        #1;
        step("rst", 32'h104, 1'b0, 32'd0);
        reset_n = 1'b1;

        // Wraparound of fetch_pc+4
        idle(32'hFFFF_FFFC);
        step("wrap", 32'h0, 1'b0, 32'd0);

        // No resolves: sequential prediction, queue fills
        idle(32'h100);
        for (int i = 0; i < 3; i++) step("seq", 32'h104, 1'b0, 32'd0);

        // Taken branch on BTB miss: flush and allocate
        drv(32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200);
        step("alloc", 32'h200, 1'b1, 32'd0);
        idle(32'h100);
        for (int i = 0; i < 3; i++) step("hit", 32'h200, 1'b0, 32'd1);

        // Taken again: correct, counter 2->3
        drv(32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200);
        step("tk2", 32'h200, 1'b0, 32'd1);
        // Not taken: flush to fall-through, counter 3->2
        drv(32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h200);
        step("ntk", 32'h104, 1'b1, 32'd1);
        idle(32'h100);
        step("still", 32'h200, 1'b0, 32'd2);
        step("fill1", 32'h200, 1'b0, 32'd2);
        step("fill2", 32'h200, 1'b0, 32'd2);

        // Flush while stalled: counter 2->1, queue cleared
        drv(32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h200);
        step("stflush", 32'h104, 1'b1, 32'd2);
        // Mismatching resolves with oldest invalid: no flush
        drv(32'h100, 1'b0, 1'b1, 1'b0, 32'h500, 1'b0, 32'h0);
        step("inv1", 32'h104, 1'b0, 32'd3);
        step("inv2", 32'h104, 1'b0, 32'd3);

        // Retrain toward taken: counter 1->2
        idle(32'h100);
        step("fill3", 32'h104, 1'b0, 32'd3);
        drv(32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200);
        step("retrain", 32'h200, 1'b1, 32'd3);
        idle(32'h100);
        for (int i = 0; i < 3; i++) step("rehit", 32'h200, 1'b0, 32'd4);

        // Non-ctrl aliasing the entry: flush and invalidate
        drv(32'h100, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0);
        step("alias", 32'h104, 1'b1, 32'd4);
        idle(32'h100);
        step("gone", 32'h104, 1'b0, 32'd5);
        step("fill4", 32'h104, 1'b0, 32'd5);
        step("fill5", 32'h104, 1'b0, 32'd5);

        // Reset during a flush cycle
        drv(32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200);
        #2;
        chk("pre_rst.flush", {31'b0, bus.is_flush}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst.flush", {31'b0, bus.is_flush}, 32'd0);
        chk("mid_rst.count", bus.mispredict_count, 32'd0);
        chk("mid_rst.next_pc", bus.next_pc, 32'h104);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(32'h100);
        step("post_rst", 32'h104, 1'b0, 32'd0);
        step("post_rst2", 32'h104, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
